// File: rtl/counter_jk_pkg.sv
// Shared constants for the 3-bit JK up/down counter.
//   CNT_W              counter width
//   CNT_MAX / CNT_MIN  terminal values for up / down counting
//   MODE_UP/MODE_DOWN  encodings of the mode input
package counter_jk_pkg;

  localparam int unsigned CNT_W = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 3'd7;
  localparam cnt_t CNT_MIN = 3'd0;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/counter_jk_jk_ff.sv
// Single JK flip-flop with synchronous active-high reset to 0.
//   clk   rising-edge clock
//   reset synchronous active-high clear
//   j, k  excitation: 00 hold, 01 clear, 10 set, 11 toggle
//   q     flop output
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // JK next-state table
  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/counter_jk.sv
// 3-bit synchronous up/down counter built from three JK flip-flops.
//   reset  synchronous active-high clear to 0
//   clk    rising-edge clock
//   mode   0 = count up, 1 = count down (sampled at the edge)
//   count  current state, straight from the flop outputs
//   tc     terminal count (only with COUNTER_JK_TC_EN defined):
//          1 when count = 7 counting up or count = 0 counting down
module counter_jk
  import counter_jk_pkg::*;
(
  input  logic             reset,
  input  logic             clk,
  input  logic             mode,
  output logic [CNT_W-1:0] count
`ifdef COUNTER_JK_TC_EN
  ,
  output logic             tc
`endif
);

  logic             down;
  logic [1:0]       rel;
  logic [CNT_W-1:0] toggle;

  // Toggle excitation: in down mode the lower bits are inverted so that
  // "all lower bits 1" becomes "all lower bits 0".
  always_comb begin
    down      = (mode == MODE_DOWN);
    rel       = count[1:0] ^ {2{down}};
    toggle[0] = 1'b1;
    toggle[1] = rel[0];
    toggle[2] = rel[0] & rel[1];
  end

  // One JK flop per bit with J = K = toggle
  for (genvar i = 0; i < int'(CNT_W); i++) begin : g_bit
    jk_ff u_jk (
      .clk   (clk),
      .reset (reset),
      .j     (toggle[i]),
      .k     (toggle[i]),
      .q     (count[i])
    );
  end

`ifdef COUNTER_JK_TC_EN
  // Terminal count is combinational on the current count and mode
  always_comb begin
    tc = ((mode == MODE_UP)   && (count == CNT_MAX)) ||
         ((mode == MODE_DOWN) && (count == CNT_MIN));
  end
`endif

endmodule

// File: tb/tb_counter_jk.sv
module tb_counter_jk;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [2:0] count;
`ifdef COUNTER_JK_TC_EN
  logic       tc;
`endif

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic       rst;
    logic       mode;
    logic [2:0] cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  counter_jk dut (
    .reset (reset),
    .clk   (clk),
    .mode  (mode),
    .count (count)
`ifdef COUNTER_JK_TC_EN
    ,
    .tc    (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2:0] exp);
    n_tests++;
    if (count !== exp) begin
      n_fail++;
      $display("FAIL %s: count got %0d expected %0d", name, count, exp);
    end
`ifdef COUNTER_JK_TC_EN
    begin
      logic exp_tc;
      exp_tc = (mode == 1'b0 && exp == 3'd7) || (mode == 1'b1 && exp == 3'd0);
      n_tests++;
      if (tc !== exp_tc) begin
        n_fail++;
        $display("FAIL %s_tc: tc got %b expected %b (mode %b)", name, tc, exp_tc, mode);
      end
    end
`endif
  endtask

  // Drive inputs mid-cycle, let one rising edge pass, then sample
  task automatic step(input logic r, input logic m, input logic [2:0] exp, input string name);
    @(negedge clk);
    reset = r;
    mode  = m;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    logic [2:0] exp;
    logic       m;

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    mode    = 1'b0;

    // reset for two edges, up count with wrap, mid-run direction change,
    // reset in down mode at 5, and a 7->0 wrap coinciding with mode change
    vecs[0]  = '{1'b1, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b0, 3'd2};
    vecs[4]  = '{1'b0, 1'b0, 3'd3};
    vecs[5]  = '{1'b0, 1'b0, 3'd4};
    vecs[6]  = '{1'b0, 1'b0, 3'd5};
    vecs[7]  = '{1'b0, 1'b0, 3'd6};
    vecs[8]  = '{1'b0, 1'b0, 3'd7};
    vecs[9]  = '{1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 3'd1};
    vecs[11] = '{1'b0, 1'b0, 3'd2};
    vecs[12] = '{1'b0, 1'b1, 3'd1};
    vecs[13] = '{1'b0, 1'b1, 3'd0};
    vecs[14] = '{1'b0, 1'b1, 3'd7};
    vecs[15] = '{1'b0, 1'b1, 3'd6};
    vecs[16] = '{1'b0, 1'b1, 3'd5};
    vecs[17] = '{1'b1, 1'b1, 3'd0};
    vecs[18] = '{1'b0, 1'b1, 3'd7};
    vecs[19] = '{1'b0, 1'b0, 3'd0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].cnt, $sformatf("vec%0d", i));
    end

    // Count up to 3, then pulse reset between edges: no asynchronous effect
    step(1'b0, 1'b0, 3'd1, "up_a");
    step(1'b0, 1'b0, 3'd2, "up_b");
    step(1'b0, 1'b0, 3'd3, "up_c");
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("async_rst_hold", 3'd3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst_pulse", 3'd4);

    // Mode change between edges leaves count untouched until the edge
    @(negedge clk);
    mode = 1'b1;
    #1;
    check("mode_mid_hold", 3'd4);
    @(posedge clk);
    #1;
    check("mode_mid_edge", 3'd3);

    // 40 edges, direction flipping every 12 edges, tracked by a model
    step(1'b1, 1'b0, 3'd0, "seq_rst0");
    step(1'b1, 1'b0, 3'd0, "seq_rst1");
    exp = 3'd0;
    for (int i = 0; i < 40; i++) begin
      m   = ((i / 12) % 2) == 1;
      exp = m ? 3'(exp - 3'd1) : 3'(exp + 3'd1);
      step(1'b0, m, exp, $sformatf("toggle%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
